// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, ALU op bit positions and divider state encoding
package pipe_pkg;
  localparam int XLEN = 32;
  localparam int ALU_OP_W = 12;
  localparam int RF_ZIP_W = 6;
  localparam int FWD_ZIP_W = 38;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_SLT = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND = 4;
  localparam int ALU_NOR = 5;
  localparam int ALU_OR = 6;
  localparam int ALU_XOR = 7;
  localparam int ALU_SLL = 8;
  localparam int ALU_SRL = 9;
  localparam int ALU_SRA = 10;
  localparam int ALU_LUI = 11;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;
endpackage

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider producing signed/unsigned quotient and remainder
module div_iter
  import pipe_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            ack,
  input  logic            is_signed,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(ITERS);
  div_state_e state, state_n;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] b_mag, rem_r, quo_r;
  logic q_neg, r_neg, b_zero;
  logic a_neg, b_neg;
  logic [XLEN+1:0] diff;
  logic ge;
  assign a_neg = is_signed & a[XLEN-1];
  assign b_neg = is_signed & b[XLEN-1];
  // trial subtraction of the divisor from the partially shifted remainder
  assign diff = {1'b0, rem_r, quo_r[XLEN-1]} - {2'b0, b_mag};
  assign ge = ~diff[XLEN+1];
  assign busy = state == DIV_RUN;
  assign done = state == DIV_DONE;
  assign quotient = b_zero ? '1 : (q_neg ? -quo_r : quo_r);
  assign remainder = r_neg ? -rem_r : rem_r;
  // next-state: start only from idle, finish after the last step, release on handoff
  always_comb begin
    state_n = state;
    if (state == DIV_IDLE && start) state_n = DIV_RUN;
    if (state == DIV_RUN && cnt == CW'(ITERS - 1)) state_n = DIV_DONE;
    if (state == DIV_DONE && ack) state_n = DIV_IDLE;
  end
  // state register and iteration counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= DIV_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == DIV_IDLE && start) cnt <= '0;
      else if (state == DIV_RUN) cnt <= cnt + CW'(1);
    end
  end
  // operand magnitudes on start, one shift-subtract step per running cycle
  always_ff @(posedge clk) begin
    if (state == DIV_IDLE && start) begin
      quo_r <= a_neg ? -a : a;
      b_mag <= b_neg ? -b : b;
      rem_r <= '0;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
      b_zero <= b == '0;
    end else if (state == DIV_RUN) begin
      rem_r <= ge ? diff[XLEN-1:0] : {rem_r[XLEN-2:0], quo_r[XLEN-1]};
      quo_r <= {quo_r[XLEN-2:0], ge};
    end
  end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: pipeline execute stage with combinational ALU and iterative divider
module exe_stage
  import pipe_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic                 exe_allowin,
  input  logic                 id_to_exe_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [ALU_OP_W-1:0]  id_alu_op,
  input  logic [XLEN-1:0]      id_alu_src1,
  input  logic [XLEN-1:0]      id_alu_src2,
  input  logic                 id_div_en,
  input  logic                 id_div_signed,
  input  logic                 id_div_rem,
  input  logic [RF_ZIP_W-1:0]  id_rf_zip,
  input  logic                 id_res_from_mem,
  input  logic                 id_mem_we,
  input  logic [XLEN-1:0]      id_rkd_value,
  input  logic                 mem_allowin,
  output logic                 exe_to_mem_valid,
  output logic [XLEN-1:0]      exe_pc,
  output logic [XLEN-1:0]      exe_alu_result,
  output logic                 exe_res_from_mem,
  output logic                 exe_mem_we,
  output logic [XLEN-1:0]      exe_rkd_value,
  output logic [RF_ZIP_W-1:0]  exe_rf_zip,
  output logic [FWD_ZIP_W-1:0] exe_fwd_zip,
  output logic                 exe_load_use
);
  logic exe_valid, exe_ready_go;
  logic [ALU_OP_W-1:0] alu_op;
  logic [XLEN-1:0] src1, src2, alu_res, quotient, remainder;
  logic div_en, div_signed, div_rem, res_from_mem, mem_we;
  logic [RF_ZIP_W-1:0] rf_zip;
  logic div_busy, div_done;
  assign exe_ready_go = ~div_en | div_done;
  assign exe_allowin = ~exe_valid | (exe_ready_go & mem_allowin);
  assign exe_to_mem_valid = exe_valid & exe_ready_go;
  // valid bit follows decode whenever the stage can accept
  always_ff @(posedge clk) begin
    if (!resetn) exe_valid <= 1'b0;
    else if (exe_allowin) exe_valid <= id_to_exe_valid;
  end
  // payload captured only on an accepted instruction
  always_ff @(posedge clk) begin
    if (id_to_exe_valid && exe_allowin) begin
      exe_pc <= id_pc;
      alu_op <= id_alu_op;
      src1 <= id_alu_src1;
      src2 <= id_alu_src2;
      div_en <= id_div_en;
      div_signed <= id_div_signed;
      div_rem <= id_div_rem;
      rf_zip <= id_rf_zip;
      res_from_mem <= id_res_from_mem;
      mem_we <= id_mem_we;
      exe_rkd_value <= id_rkd_value;
    end
  end
  // one-hot op select; an all-zero op leaves every term masked to zero
  always_comb begin
    alu_res = ({XLEN{alu_op[ALU_ADD]}} & (src1 + src2))
            | ({XLEN{alu_op[ALU_SUB]}} & (src1 - src2))
            | ({XLEN{alu_op[ALU_SLT]}} & {31'b0, $signed(src1) < $signed(src2)})
            | ({XLEN{alu_op[ALU_SLTU]}} & {31'b0, src1 < src2})
            | ({XLEN{alu_op[ALU_AND]}} & (src1 & src2))
            | ({XLEN{alu_op[ALU_NOR]}} & ~(src1 | src2))
            | ({XLEN{alu_op[ALU_OR]}} & (src1 | src2))
            | ({XLEN{alu_op[ALU_XOR]}} & (src1 ^ src2))
            | ({XLEN{alu_op[ALU_SLL]}} & (src1 << src2[4:0]))
            | ({XLEN{alu_op[ALU_SRL]}} & (src1 >> src2[4:0]))
            | ({XLEN{alu_op[ALU_SRA]}} & XLEN'($signed(src1) >>> src2[4:0]))
            | ({XLEN{alu_op[ALU_LUI]}} & src2);
  end
  div_iter #(.ITERS(DIV_ITERS)) u_div (
    .clk(clk),
    .resetn(resetn),
    .start(exe_valid & div_en & ~div_busy & ~div_done),
    .ack(exe_to_mem_valid & mem_allowin),
    .is_signed(div_signed),
    .a(src1),
    .b(src2),
    .busy(div_busy),
    .done(div_done),
    .quotient(quotient),
    .remainder(remainder)
  );
  assign exe_alu_result = div_en ? (div_rem ? remainder : quotient) : alu_res;
  assign exe_res_from_mem = exe_to_mem_valid & res_from_mem;
  assign exe_mem_we = exe_to_mem_valid & mem_we;
  assign exe_rf_zip = {exe_valid & rf_zip[RF_ZIP_W-1], rf_zip[RF_ZIP_W-2:0]};
  assign exe_fwd_zip = {exe_valid & rf_zip[RF_ZIP_W-1], rf_zip[RF_ZIP_W-2:0], exe_alu_result};
  assign exe_load_use = exe_valid & res_from_mem;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed table and sequence checks of the execute stage
module tb_exe_stage;
  import pipe_pkg::*;
  logic clk = 0, resetn = 0;
  logic exe_allowin, id_to_exe_valid, id_div_en, id_div_signed, id_div_rem;
  logic [31:0] id_pc, id_alu_src1, id_alu_src2, id_rkd_value;
  logic [11:0] id_alu_op;
  logic [5:0] id_rf_zip, exe_rf_zip;
  logic id_res_from_mem, id_mem_we, mem_allowin, exe_to_mem_valid;
  logic [31:0] exe_pc, exe_alu_result, exe_rkd_value;
  logic exe_res_from_mem, exe_mem_we, exe_load_use;
  logic [37:0] exe_fwd_zip;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    string nm;
    logic [11:0] op;
    logic [31:0] a, b, exp;
  } alu_vec_t;
  alu_vec_t vt[13];
  always #5 clk = ~clk;
  exe_stage dut (
    .clk(clk), .resetn(resetn), .exe_allowin(exe_allowin),
    .id_to_exe_valid(id_to_exe_valid), .id_pc(id_pc), .id_alu_op(id_alu_op),
    .id_alu_src1(id_alu_src1), .id_alu_src2(id_alu_src2), .id_div_en(id_div_en),
    .id_div_signed(id_div_signed), .id_div_rem(id_div_rem), .id_rf_zip(id_rf_zip),
    .id_res_from_mem(id_res_from_mem), .id_mem_we(id_mem_we), .id_rkd_value(id_rkd_value),
    .mem_allowin(mem_allowin), .exe_to_mem_valid(exe_to_mem_valid), .exe_pc(exe_pc),
    .exe_alu_result(exe_alu_result), .exe_res_from_mem(exe_res_from_mem),
    .exe_mem_we(exe_mem_we), .exe_rkd_value(exe_rkd_value), .exe_rf_zip(exe_rf_zip),
    .exe_fwd_zip(exe_fwd_zip), .exe_load_use(exe_load_use)
  );
  task automatic chk(input string nm, input logic [37:0] act, input logic [37:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic set_in(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dv, input logic sg, input logic rm, input logic [31:0] pc,
                        input logic [5:0] rz, input logic ld, input logic st);
    id_alu_op = op; id_alu_src1 = a; id_alu_src2 = b; id_div_en = dv; id_div_signed = sg;
    id_div_rem = rm; id_pc = pc; id_rf_zip = rz; id_res_from_mem = ld; id_mem_we = st;
    id_rkd_value = ~a;
  endtask
  task automatic issue(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic dv, input logic sg, input logic rm, input logic [31:0] pc,
                       input logic [5:0] rz, input logic ld, input logic st);
    set_in(op, a, b, dv, sg, rm, pc, rz, ld, st);
    id_to_exe_valid = 1;
    @(posedge clk); #1;
    id_to_exe_valid = 0;
  endtask
  task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic rm, input logic [31:0] exp);
    int n = 0;
    logic bad = 0;
    issue(12'h0, a, b, 1, sg, rm, 32'h40, 6'h21, 0, 0);
    while (!exe_to_mem_valid && n < 100) begin
      if (exe_allowin) bad = 1;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 38'(n), 38'd33);
    chk({nm, " allowin low"}, 38'(bad), 38'd0);
    chk({nm, " result"}, 38'(exe_alu_result), 38'(exp));
    @(posedge clk); #1;
    chk({nm, " single pulse"}, 38'(exe_to_mem_valid), 38'd0);
  endtask
  initial begin
    int n, xfers;
    vt[0] = '{"add", 12'h001, 32'h7FFFFFFF, 32'h1, 32'h80000000};
    vt[1] = '{"sub", 12'h002, 32'h5, 32'h7, 32'hFFFFFFFE};
    vt[2] = '{"slt", 12'h004, 32'hFFFFFFFF, 32'h1, 32'h1};
    vt[3] = '{"sltu", 12'h008, 32'hFFFFFFFF, 32'h1, 32'h0};
    vt[4] = '{"and", 12'h010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vt[5] = '{"nor", 12'h020, 32'h0, 32'h0, 32'hFFFFFFFF};
    vt[6] = '{"or", 12'h040, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0};
    vt[7] = '{"xor", 12'h080, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
    vt[8] = '{"sll", 12'h100, 32'h1, 32'h3F, 32'h80000000};
    vt[9] = '{"srl", 12'h200, 32'h80000000, 32'h4, 32'h08000000};
    vt[10] = '{"sra", 12'h400, 32'h80000000, 32'h4, 32'hF8000000};
    vt[11] = '{"lui", 12'h800, 32'h1234, 32'h12345000, 32'h12345000};
    vt[12] = '{"zero op", 12'h000, 32'h1234, 32'h5678, 32'h0};
    id_to_exe_valid = 0; mem_allowin = 1;
    set_in(12'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk); #1;
    chk("reset allowin", 38'(exe_allowin), 38'd1);
    chk("reset to_mem_valid", 38'(exe_to_mem_valid), 38'd0);
    chk("reset load_use", 38'(exe_load_use), 38'd0);
    chk("reset fwd we", 38'(exe_fwd_zip[37]), 38'd0);
    chk("reset rf we", 38'(exe_rf_zip[5]), 38'd0);
    chk("reset mem req", 38'({exe_res_from_mem, exe_mem_we}), 38'd0);
    resetn = 1;
    for (int i = 0; i < 13; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, 0, 0, 0, 32'h1000 + i, 6'h25, 0, 0);
      chk({vt[i].nm, " result"}, 38'(exe_alu_result), 38'(vt[i].exp));
      chk({vt[i].nm, " valid"}, 38'(exe_to_mem_valid), 38'd1);
      @(posedge clk); #1;
      chk({vt[i].nm, " pulse"}, 38'(exe_to_mem_valid), 38'd0);
    end
    do_div("sdiv -7/2 q", 32'hFFFFFFF9, 32'h2, 1, 0, 32'hFFFFFFFD);
    do_div("sdiv -7/2 r", 32'hFFFFFFF9, 32'h2, 1, 1, 32'hFFFFFFFF);
    do_div("udiv 100/0 q", 32'd100, 32'h0, 0, 0, 32'hFFFFFFFF);
    do_div("udiv 100/0 r", 32'd100, 32'h0, 0, 1, 32'd100);
    do_div("sdiv -7/0 r", 32'hFFFFFFF9, 32'h0, 1, 1, 32'hFFFFFFF9);
    do_div("sdiv min/-1 q", 32'h80000000, 32'hFFFFFFFF, 1, 0, 32'h80000000);
    do_div("sdiv min/-1 r", 32'h80000000, 32'hFFFFFFFF, 1, 1, 32'h0);
    mem_allowin = 0;
    issue(12'h0, 32'd100, 32'd7, 1, 0, 0, 32'h100, 6'h22, 0, 0);
    n = 0;
    while (!exe_to_mem_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp reaches done", 38'(exe_to_mem_valid), 38'd1);
    for (int i = 0; i < 5; i++) begin
      set_in(12'h001, 32'h1, 32'h1, 0, 0, 0, 32'h200, 6'h23, 0, 0);
      id_to_exe_valid = 1;
      @(posedge clk); #1;
      chk("bp result", 38'(exe_alu_result), 38'd14);
      chk("bp pc", 38'(exe_pc), 38'h100);
      chk("bp allowin", 38'(exe_allowin), 38'd0);
      chk("bp valid", 38'(exe_to_mem_valid), 38'd1);
    end
    id_to_exe_valid = 0; mem_allowin = 1;
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      if (exe_to_mem_valid) xfers++;
      @(posedge clk); #1;
    end
    chk("bp transfers", 38'(xfers), 38'd1);
    chk("pre-load res_from_mem", 38'(exe_res_from_mem), 38'd0);
    issue(12'h001, 32'h1000, 32'h4, 0, 0, 0, 32'h300, 6'h23, 1, 0);
    chk("load use", 38'(exe_load_use), 38'd1);
    chk("load fwd", 38'(exe_fwd_zip), {1'b1, 5'd3, 32'h1004});
    chk("load res_from_mem", 38'(exe_res_from_mem), 38'd1);
    issue(12'h001, 32'h8, 32'h8, 0, 0, 0, 32'h304, 6'h24, 0, 1);
    chk("dep load_use", 38'(exe_load_use), 38'd0);
    chk("dep res_from_mem", 38'(exe_res_from_mem), 38'd0);
    chk("store mem_we", 38'(exe_mem_we), 38'd1);
    chk("store data", 38'(exe_rkd_value), 38'hFFFFFFF7);
    @(posedge clk); #1;
    chk("store drop", 38'(exe_mem_we), 38'd0);
    issue(12'h0, 32'd1000, 32'd3, 1, 1, 0, 32'h400, 6'h25, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid-div allowin", 38'(exe_allowin), 38'd0);
    chk("mid-div fwd we", 38'(exe_fwd_zip[37]), 38'd1);
    resetn = 0;
    @(posedge clk); #1;
    chk("rst mid-div allowin", 38'(exe_allowin), 38'd1);
    chk("rst mid-div valid", 38'(exe_to_mem_valid), 38'd0);
    chk("rst mid-div fwd we", 38'(exe_fwd_zip[37]), 38'd0);
    resetn = 1;
    do_div("udiv 9/3 after rst", 32'd9, 32'd3, 0, 0, 32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
